// File: rtl/rename_map_nway.sv
`default_nettype none
// ============================================================================
// Module   : rename_map_nway
// Brief    : N-wide register renamer. Holds a speculative RAT, a committed
//            RAT and a circular free list, with intra-group dependency bypass
//            and single-cycle flush recovery.
// Revision : 1.0 - initial release
// ============================================================================
module rename_map_nway #(
    parameter  int NUM_ARCH = 32,
    parameter  int NUM_PHYS = 64,
    parameter  int WIDTH    = 2,
    localparam int AW       = $clog2(NUM_ARCH),
    localparam int PW       = $clog2(NUM_PHYS),
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH,
    localparam int CW       = $clog2(FL_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    // rename group from decode
    input  logic [WIDTH-1:0]    rn_valid,
    input  logic [WIDTH*AW-1:0] rn_rs1,
    input  logic [WIDTH*AW-1:0] rn_rs2,
    input  logic [WIDTH*AW-1:0] rn_rd,
    input  logic [WIDTH-1:0]    rn_rd_we,
    output logic                rn_ready,
    output logic [WIDTH*PW-1:0] rn_rs1_p,
    output logic [WIDTH*PW-1:0] rn_rs2_p,
    output logic [WIDTH*PW-1:0] rn_new_p,
    output logic [WIDTH*PW-1:0] rn_old_p,
    output logic [WIDTH-1:0]    rn_alloc,
    // in-order commit lanes
    input  logic [WIDTH-1:0]    cm_valid,
    input  logic [WIDTH*AW-1:0] cm_arch,
    input  logic [WIDTH*PW-1:0] cm_new_p,
    input  logic [WIDTH*PW-1:0] cm_old_p,
    // recovery and status
    input  logic                flush,
    output logic [CW-1:0]       free_count,
    output logic                err
);

    localparam int FPW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int LCW = $clog2(WIDTH + 1);

    logic [PW-1:0]  spec_rat  [NUM_ARCH];
    logic [PW-1:0]  arch_rat  [NUM_ARCH];
    logic [PW-1:0]  arch_next [NUM_ARCH];
    logic [PW-1:0]  fl        [FL_DEPTH];
    logic [FPW-1:0] head;
    logic [FPW-1:0] tail;
    logic [FPW-1:0] commit_head;

    logic [WIDTH-1:0] lane_alloc;
    logic [PW-1:0]    lane_new [WIDTH];
    logic [LCW-1:0]   alloc_count;
    logic [WIDTH-1:0] push_en;
    logic [FPW-1:0]   push_idx [WIDTH];
    logic [LCW-1:0]   push_count;
    logic             bad_any;
    logic             fire;

    // Circular pointer advance; the list depth need not be a power of two.
    // A single wrap suffices because at most WIDTH <= FL_DEPTH steps are taken.
    function automatic logic [FPW-1:0] ptr_add(input logic [FPW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= FL_DEPTH) s = s - FL_DEPTH;
        return s[FPW-1:0];
    endfunction

    // Group may rename only with room for a full group, judged on the registered count.
    assign rn_ready = (int'(free_count) >= WIDTH) && !flush;
    assign fire     = rn_ready & rn_valid[0];

    // Decide which lanes allocate and hand them consecutive free-list entries.
    always_comb begin
        logic [LCW-1:0] acnt;
        acnt       = '0;
        lane_alloc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_alloc[i] = rn_valid[i] & rn_rd_we[i] & (rn_rd[i*AW +: AW] != '0);
            lane_new[i]   = lane_alloc[i] ? fl[ptr_add(head, int'(acnt))] : '0;
            acnt          = acnt + LCW'(lane_alloc[i]);
        end
        alloc_count = acnt;
    end

    // Source and previous-dest lookup with bypass from older lanes of the same group.
    always_comb begin
        logic [PW-1:0] s1;
        logic [PW-1:0] s2;
        logic [PW-1:0] od;
        rn_rs1_p = '0;
        rn_rs2_p = '0;
        rn_old_p = '0;
        rn_new_p = '0;
        rn_alloc = lane_alloc;
        for (int i = 0; i < WIDTH; i++) begin
            s1 = spec_rat[rn_rs1[i*AW +: AW]];
            s2 = spec_rat[rn_rs2[i*AW +: AW]];
            od = spec_rat[rn_rd[i*AW +: AW]];
            // later (younger) writers override, so the nearest older lane wins
            for (int j = 0; j < i; j++) begin
                if (lane_alloc[j] && (rn_rd[j*AW +: AW] == rn_rs1[i*AW +: AW])) s1 = lane_new[j];
                if (lane_alloc[j] && (rn_rd[j*AW +: AW] == rn_rs2[i*AW +: AW])) s2 = lane_new[j];
                if (lane_alloc[j] && (rn_rd[j*AW +: AW] == rn_rd[i*AW +: AW]))  od = lane_new[j];
            end
            if (rn_rs1[i*AW +: AW] == '0) s1 = '0;
            if (rn_rs2[i*AW +: AW] == '0) s2 = '0;
            rn_rs1_p[i*PW +: PW] = s1;
            rn_rs2_p[i*PW +: PW] = s2;
            rn_old_p[i*PW +: PW] = lane_alloc[i] ? od : '0;
            rn_new_p[i*PW +: PW] = lane_new[i];
        end
    end

    // Commit decode: next committed map, free-list push slots and illegal-commit detect.
    always_comb begin
        logic [LCW-1:0] pcnt;
        pcnt      = '0;
        bad_any   = 1'b0;
        push_en   = '0;
        arch_next = arch_rat;
        for (int k = 0; k < WIDTH; k++) begin
            push_idx[k] = ptr_add(tail, int'(pcnt));
            if (cm_valid[k] && (cm_arch[k*AW +: AW] != '0)) begin
                if (cm_new_p[k*PW +: PW] != '0) begin
                    push_en[k]                      = 1'b1;
                    arch_next[cm_arch[k*AW +: AW]]  = cm_new_p[k*PW +: PW];
                    pcnt                            = pcnt + 1'b1;
                end else begin
                    bad_any = 1'b1;
                end
            end
        end
        push_count = pcnt;
    end

    // State update: commits every cycle, then flush recovery or a fired rename.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                spec_rat[a] <= PW'(a);
                arch_rat[a] <= PW'(a);
            end
            for (int f = 0; f < FL_DEPTH; f++) begin
                fl[f] <= PW'(NUM_ARCH + f);
            end
            head        <= '0;
            tail        <= '0;
            commit_head <= '0;
            free_count  <= CW'(FL_DEPTH);
            err         <= 1'b0;
        end else begin
            arch_rat <= arch_next;
            for (int k = 0; k < WIDTH; k++) begin
                if (push_en[k]) fl[push_idx[k]] <= cm_old_p[k*PW +: PW];
            end
            tail        <= ptr_add(tail, int'(push_count));
            commit_head <= ptr_add(commit_head, int'(push_count));
            err         <= err | bad_any;
            if (flush) begin
                // every uncommitted allocation is reclaimed, so the list is full again
                spec_rat   <= arch_next;
                head       <= ptr_add(commit_head, int'(push_count));
                free_count <= CW'(FL_DEPTH);
            end else if (fire) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (lane_alloc[i]) spec_rat[rn_rd[i*AW +: AW]] <= lane_new[i];
                end
                head       <= ptr_add(head, int'(alloc_count));
                free_count <= free_count + CW'(push_count) - CW'(alloc_count);
            end else begin
                free_count <= free_count + CW'(push_count);
            end
        end
    end

`ifndef SYNTHESIS
    // Occupancy must stay within [0, FL_DEPTH] when commits are legal.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (int'(free_count) + int'(push_count) - (fire ? int'(alloc_count) : 0) <= FL_DEPTH)
                else $error("free list overflow");
            assert (int'(free_count) + int'(push_count) - (fire ? int'(alloc_count) : 0) >= 0)
                else $error("free list underflow");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_map_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_map_nway
// Brief    : Self-checking bench for rename_map_nway against a sequential
//            rename model (map arrays, free-list queue, in-flight queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_map_nway;

    localparam int NA = 32;
    localparam int NP = 64;
    localparam int W  = 2;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int FD = NP - NA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]    rn_valid;
    logic [W*AW-1:0] rn_rs1, rn_rs2, rn_rd;
    logic [W-1:0]    rn_rd_we;
    logic            rn_ready;
    logic [W*PW-1:0] rn_rs1_p, rn_rs2_p, rn_new_p, rn_old_p;
    logic [W-1:0]    rn_alloc;
    logic [W-1:0]    cm_valid;
    logic [W*AW-1:0] cm_arch;
    logic [W*PW-1:0] cm_new_p, cm_old_p;
    logic            flush;
    logic [5:0]      free_count;
    logic            err;

    rename_map_nway #(.NUM_ARCH(NA), .NUM_PHYS(NP), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .rn_valid(rn_valid), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd),
        .rn_rd_we(rn_rd_we), .rn_ready(rn_ready),
        .rn_rs1_p(rn_rs1_p), .rn_rs2_p(rn_rs2_p), .rn_new_p(rn_new_p),
        .rn_old_p(rn_old_p), .rn_alloc(rn_alloc),
        .cm_valid(cm_valid), .cm_arch(cm_arch), .cm_new_p(cm_new_p), .cm_old_p(cm_old_p),
        .flush(flush), .free_count(free_count), .err(err)
    );

    typedef struct {
        int arch;
        int np;
        int op;
    } rec_t;

    int n_vec = 0;
    int n_bad = 0;

    // stimulus for the current cycle
    int in_v[W], in_we[W], in_rs1[W], in_rs2[W], in_rd[W];
    int cv[W], ca[W], cn[W], co[W];
    int fl_in;
    int ncm_rob;

    // reference model
    int   spec_map[NA];
    int   arch_map[NA];
    int   fl_q[$];
    rec_t rob[$];
    int   m_err;
    int   exp_fire;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < NA; a++) begin
            spec_map[a] = a;
            arch_map[a] = a;
        end
        fl_q.delete();
        for (int p = NA; p < NP; p++) fl_q.push_back(p);
        rob.delete();
        m_err = 0;
    endtask

    task automatic clear_in();
        for (int i = 0; i < W; i++) begin
            in_v[i] = 0; in_we[i] = 0; in_rs1[i] = 0; in_rs2[i] = 0; in_rd[i] = 0;
            cv[i] = 0; ca[i] = $urandom_range(0, NA-1);
            cn[i] = $urandom_range(0, NP-1); co[i] = $urandom_range(0, NP-1);
        end
        fl_in   = 0;
        ncm_rob = 0;
    endtask

    task automatic set_commit(input int n);
        for (int k = 0; k < n; k++) begin
            cv[k] = 1; ca[k] = rob[k].arch; cn[k] = rob[k].np; co[k] = rob[k].op;
        end
        ncm_rob = n;
    endtask

    task automatic apply();
        for (int i = 0; i < W; i++) begin
            rn_valid[i]          = in_v[i][0];
            rn_rd_we[i]          = in_we[i][0];
            rn_rs1[i*AW +: AW]   = AW'(in_rs1[i]);
            rn_rs2[i*AW +: AW]   = AW'(in_rs2[i]);
            rn_rd[i*AW +: AW]    = AW'(in_rd[i]);
            cm_valid[i]          = cv[i][0];
            cm_arch[i*AW +: AW]  = AW'(ca[i]);
            cm_new_p[i*PW +: PW] = PW'(cn[i]);
            cm_old_p[i*PW +: PW] = PW'(co[i]);
        end
        flush = fl_in[0];
    endtask

    // Compare DUT outputs with the model, renaming lanes one after another.
    task automatic settle();
        int tmp[NA];
        bit unk[NA];
        bit live[NP];
        int k, al, exp_ready;
        logic [PW-1:0] dn;
        #1;
        for (int a = 0; a < NA; a++) begin tmp[a] = spec_map[a]; unk[a] = 0; end
        for (int p = 0; p < NP; p++) live[p] = 0;
        for (int a = 0; a < NA; a++) live[arch_map[a]] = 1;
        foreach (rob[r]) live[rob[r].np] = 1;
        exp_ready = (fl_q.size() >= W) && (fl_in == 0);
        exp_fire  = exp_ready && (in_v[0] != 0);
        check("ready", rn_ready, exp_ready);
        check("free_count", free_count, fl_q.size());
        check("err", err, m_err);
        k = 0;
        for (int i = 0; i < W; i++) begin
            al = (in_v[i] != 0) && (in_we[i] != 0) && (in_rd[i] != 0);
            check($sformatf("alloc[%0d]", i), rn_alloc[i], al);
            if (in_v[i] != 0) begin
                if (!unk[in_rs1[i]]) check($sformatf("rs1_p[%0d]", i), rn_rs1_p[i*PW +: PW], tmp[in_rs1[i]]);
                if (!unk[in_rs2[i]]) check($sformatf("rs2_p[%0d]", i), rn_rs2_p[i*PW +: PW], tmp[in_rs2[i]]);
                if (al != 0) begin
                    dn = rn_new_p[i*PW +: PW];
                    if (!unk[in_rd[i]]) check($sformatf("old_p[%0d]", i), rn_old_p[i*PW +: PW], tmp[in_rd[i]]);
                    if (k < fl_q.size()) begin
                        check($sformatf("new_p[%0d]", i), dn, fl_q[k]);
                        tmp[in_rd[i]] = fl_q[k];
                        unk[in_rd[i]] = 0;
                    end else begin
                        unk[in_rd[i]] = 1;
                    end
                    if (exp_fire != 0) begin
                        check($sformatf("dup_live[%0d]", i), live[dn], 0);
                        live[dn] = 1;
                    end
                    k++;
                end else begin
                    check($sformatf("old_p0[%0d]", i), rn_old_p[i*PW +: PW], 0);
                    check($sformatf("new_p0[%0d]", i), rn_new_p[i*PW +: PW], 0);
                end
            end
        end
    endtask

    // Apply this cycle's commits, then flush or rename, then move to the next cycle.
    task automatic advance();
        int pushes[$];
        int np;
        for (int c = 0; c < W; c++) begin
            if (cv[c] != 0 && ca[c] != 0) begin
                if (cn[c] != 0) begin
                    arch_map[ca[c]] = cn[c];
                    pushes.push_back(co[c]);
                end else begin
                    m_err = 1;
                end
            end
        end
        repeat (ncm_rob) void'(rob.pop_front());
        if (fl_in != 0) begin
            for (int a = 0; a < NA; a++) spec_map[a] = arch_map[a];
            for (int r = rob.size() - 1; r >= 0; r--) fl_q.push_front(rob[r].np);
            rob.delete();
        end else if (exp_fire != 0) begin
            for (int i = 0; i < W; i++) begin
                if (in_v[i] != 0 && in_we[i] != 0 && in_rd[i] != 0) begin
                    rec_t rc;
                    np = fl_q.pop_front();
                    rc.arch = in_rd[i];
                    rc.np   = np;
                    rc.op   = spec_map[in_rd[i]];
                    spec_map[in_rd[i]] = np;
                    rob.push_back(rc);
                end
            end
        end
        foreach (pushes[q]) fl_q.push_back(pushes[q]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_in();
        apply();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // single lane rename then read-back
        do_reset();
        clear_in(); in_v[0] = 1; in_we[0] = 1; in_rd[0] = 5; apply(); settle();
        check("t1_new", rn_new_p[0 +: PW], 32);
        check("t1_old", rn_old_p[0 +: PW], 5);
        check("t1_fc0", free_count, 32);
        advance();
        clear_in(); in_v[0] = 1; in_rs1[0] = 5; apply(); settle();
        check("t1_rs1", rn_rs1_p[0 +: PW], 32);
        check("t1_fc1", free_count, 31);
        advance();

        // same-group dependency
        do_reset();
        clear_in();
        in_v[0] = 1; in_we[0] = 1; in_rd[0] = 3;
        in_v[1] = 1; in_we[1] = 1; in_rd[1] = 3; in_rs1[1] = 3;
        apply(); settle();
        check("t2_rs1", rn_rs1_p[PW +: PW], 32);
        check("t2_old", rn_old_p[PW +: PW], 32);
        check("t2_new", rn_new_p[PW +: PW], 33);
        advance();
        clear_in(); in_v[0] = 1; in_rs1[0] = 3; apply(); settle();
        check("t2_map", rn_rs1_p[0 +: PW], 33);
        advance();

        // exhaustion and return of freed registers
        do_reset();
        for (int g = 0; g < 16; g++) begin
            clear_in();
            in_v[0] = 1; in_we[0] = 1; in_rd[0] = (2*g) % 31 + 1;
            in_v[1] = 1; in_we[1] = 1; in_rd[1] = (2*g + 1) % 31 + 1;
            apply(); settle(); advance();
        end
        clear_in(); set_commit(2); apply(); settle();
        check("t3_fc0", free_count, 0);
        check("t3_rdy0", rn_ready, 0);
        check("t3_cmold", cm_old_p, {6'd2, 6'd1});
        advance();
        clear_in();
        in_v[0] = 1; in_we[0] = 1; in_rd[0] = 20;
        in_v[1] = 1; in_we[1] = 1; in_rd[1] = 21;
        apply(); settle();
        check("t3_rdy1", rn_ready, 1);
        check("t3_new0", rn_new_p[0 +: PW], 1);
        check("t3_new1", rn_new_p[PW +: PW], 2);
        advance();

        // flush with one same-cycle commit
        do_reset();
        clear_in();
        in_v[0] = 1; in_we[0] = 1; in_rd[0] = 7;
        in_v[1] = 1; in_we[1] = 1; in_rd[1] = 8;
        apply(); settle(); advance();
        clear_in(); in_v[0] = 1; in_we[0] = 1; in_rd[0] = 9; apply(); settle(); advance();
        clear_in(); fl_in = 1; set_commit(1); apply(); settle();
        check("t4_rdy", rn_ready, 0);
        advance();
        clear_in(); in_v[0] = 1; in_we[0] = 1; in_rd[0] = 10; in_rs1[0] = 7; in_rs2[0] = 8;
        apply(); settle();
        check("t4_new", rn_new_p[0 +: PW], 33);
        check("t4_rs1", rn_rs1_p[0 +: PW], 32);
        check("t4_rs2", rn_rs2_p[0 +: PW], 8);
        check("t4_fc0", free_count, 32);
        advance();
        clear_in(); apply(); settle();
        check("t4_fc1", free_count, 31);
        advance();

        // pointer wrap-around with steady alloc/commit traffic
        do_reset();
        for (int c = 0; c < 40; c++) begin
            clear_in();
            in_v[0] = 1; in_we[0] = 1; in_rd[0] = $urandom_range(1, NA-1);
            in_v[1] = 1; in_we[1] = 1; in_rd[1] = $urandom_range(1, NA-1);
            in_rs1[1] = in_rd[0];
            if (rob.size() >= 2) set_commit(2);
            apply(); settle(); advance();
        end

        // randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            int nv, nc;
            clear_in();
            nv = $urandom_range(0, W);
            for (int i = 0; i < nv; i++) begin
                in_v[i]   = 1;
                in_we[i]  = $urandom_range(0, 3) != 0;
                in_rd[i]  = $urandom_range(0, 7);
                in_rs1[i] = $urandom_range(0, 7);
                in_rs2[i] = $urandom_range(0, 7);
            end
            fl_in = ($urandom_range(0, 24) == 0);
            nc = $urandom_range(0, W);
            if (nc > rob.size()) nc = rob.size();
            set_commit(nc);
            apply(); settle(); advance();
        end

        // illegal commit: sticky err, no map or list change
        do_reset();
        clear_in(); cv[0] = 1; ca[0] = 4; cn[0] = 0; co[0] = 9; apply(); settle(); advance();
        clear_in(); apply(); settle();
        check("t6_err", err, 1);
        check("t6_fc", free_count, 32);
        advance();
        clear_in(); fl_in = 1; apply(); settle(); advance();
        clear_in(); in_v[0] = 1; in_rs1[0] = 4; apply(); settle();
        check("t6_map4", rn_rs1_p[0 +: PW], 4);
        check("t6_sticky", err, 1);
        advance();
        do_reset();
        clear_in(); apply(); settle();
        check("t6_clr", err, 0);
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
